// File: rtl/nibbler_phase_sequencer_pkg.sv
// Shared types for the Nibbler fetch/execute sequencer.
package nibbler_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        S_INIT,
        S_HALTED,
        S_FETCH,
        S_EXEC
    } seq_state_t;

    localparam logic PH_FETCH = 1'b0;
    localparam logic PH_EXEC  = 1'b1;

endpackage

// File: rtl/nibbler_phase_sequencer_if.sv
// Debug/board-side control and datapath-side phase signals of the sequencer.
interface nibbler_phase_sequencer_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 16
);
    logic              run;
    logic              halt;
    logic              step;
    logic              bpEnable;
    logic [ADDR_W-1:0] bpAddr;
    logic [ADDR_W-1:0] pc;
    logic              ph;
    logic              loadIR;
    logic              cpuEn;
    logic              halted;
    logic              bpHit;
    logic [CNT_W-1:0]  instrCount;

    modport master (
        output run, halt, step, bpEnable, bpAddr, pc,
        input  ph, loadIR, cpuEn, halted, bpHit, instrCount
    );

    modport slave (
        input  run, halt, step, bpEnable, bpAddr, pc,
        output ph, loadIR, cpuEn, halted, bpHit, instrCount
    );
endinterface

// File: rtl/nibbler_phase_sequencer_bp_unit.sv
// PC breakpoint compare with the skip flag (lets a resumed fetch pass its own breakpoint)
// and the sticky hit indicator.
module nibbler_phase_sequencer_bp_unit #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_in_fetch,
    input  logic              i_set_skip,
    input  logic              i_clr_skip,
    input  logic              i_bp_enable,
    input  logic [ADDR_W-1:0] i_bp_addr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_bp_match,
    output logic              o_bp_hit
);
    logic r_bp_skip;
    logic r_bp_hit;

    assign o_bp_match = i_bp_enable && (i_pc == i_bp_addr) && !r_bp_skip;
    assign o_bp_hit   = r_bp_hit;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bp_skip <= 1'b0;
            r_bp_hit  <= 1'b0;
        end else if (i_set_skip) begin
            r_bp_skip <= 1'b1;
            r_bp_hit  <= 1'b0;
        end else begin
            if (i_clr_skip) r_bp_skip <= 1'b0;
            if (i_in_fetch && o_bp_match) r_bp_hit <= 1'b1;
        end
    end
endmodule

// File: rtl/nibbler_phase_sequencer.sv
// Fetch/execute phase sequencer with run/halt/single-step control, PC breakpoint and
// retired-instruction counter.
module nibbler_phase_sequencer
    import nibbler_phase_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned RESET_CYCLES  = 2,
    parameter bit          START_RUNNING = 1'b1
) (
    input logic                     i_clock,
    input logic                     i_reset,
    nibbler_phase_sequencer_if.slave bus
);
    localparam int unsigned INIT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(RESET_CYCLES - 1);

    seq_state_t         r_state;
    logic [INIT_W-1:0]  r_init_cnt;
    logic               r_ph;
    logic               r_halted;
    logic               r_halt_pend;
    logic               r_step_mode;
    logic [CNT_W-1:0]   r_instr_count;

    logic w_in_fetch;
    logic w_in_exec;
    logic w_leave_halted;
    logic w_bp_match;
    logic w_bp_hit;
    logic w_go;

    assign w_in_fetch     = (r_state == S_FETCH);
    assign w_in_exec      = (r_state == S_EXEC);
    assign w_leave_halted = (r_state == S_HALTED) && (bus.run || bus.step);
    assign w_go           = w_in_fetch && !w_bp_match;

    nibbler_phase_sequencer_bp_unit #(
        .ADDR_W (ADDR_W)
    ) u_bp_unit (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_in_fetch  (w_in_fetch),
        .i_set_skip  (w_leave_halted),
        .i_clr_skip  (w_in_exec),
        .i_bp_enable (bus.bpEnable),
        .i_bp_addr   (bus.bpAddr),
        .i_pc        (bus.pc),
        .o_bp_match  (w_bp_match),
        .o_bp_hit    (w_bp_hit)
    );

    // Breakpoint is taken before the fetch, so loadIR/cpuEn are Mealy on the match.
    assign bus.ph         = r_ph;
    assign bus.loadIR     = w_go;
    assign bus.cpuEn      = w_go || w_in_exec;
    assign bus.halted     = r_halted;
    assign bus.bpHit      = w_bp_hit;
    assign bus.instrCount = r_instr_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_INIT;
            r_init_cnt    <= '0;
            r_ph          <= PH_FETCH;
            r_halted      <= 1'b1;
            r_halt_pend   <= 1'b0;
            r_step_mode   <= 1'b0;
            r_instr_count <= '0;
        end else begin
            unique case (r_state)
                S_INIT: begin
                    if (bus.halt) r_halt_pend <= 1'b1;
                    if (r_init_cnt == INIT_LAST) begin
                        if (START_RUNNING && !r_halt_pend) begin
                            r_state  <= S_FETCH;
                            r_halted <= 1'b0;
                        end else begin
                            r_state     <= S_HALTED;
                            r_halt_pend <= 1'b0;
                        end
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.halt) r_halt_pend <= 1'b1;
                    if (w_bp_match) begin
                        r_state     <= S_HALTED;
                        r_halted    <= 1'b1;
                        r_halt_pend <= 1'b0;
                        r_step_mode <= 1'b0;
                    end else begin
                        r_state <= S_EXEC;
                        r_ph    <= PH_EXEC;
                    end
                end
                S_EXEC: begin
                    r_instr_count <= r_instr_count + 1'b1;
                    r_ph          <= PH_FETCH;
                    if (bus.halt) r_halt_pend <= 1'b1;
                    if (r_halt_pend || r_step_mode) begin
                        r_state     <= S_HALTED;
                        r_halted    <= 1'b1;
                        r_halt_pend <= 1'b0;
                        r_step_mode <= 1'b0;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    // run dominates step; halt is ignored while halted
                    if (bus.run || bus.step) begin
                        r_state     <= S_FETCH;
                        r_halted    <= 1'b0;
                        r_step_mode <= !bus.run;
                    end
                end
            endcase
        end
    end
endmodule
